tft_window_scheduler: RTL and testbench

//   Sits between the TFT timing generator and the image/char/digit ROM datapath.
//   - Maps the global active-area pixel coordinate onto three display windows: veneno, xiaofang and num.
//   - Arbitrates overlapping windows by fixed priority.
//   - Drives the one-hot per-window request and window-local x/y that the image block uses to form ROM addresses.
//   - Owns the frame-locked 0-9 digit sequencer, and window repositioning through frame-synchronous shadow registers.

---
 rtl/tft_window_scheduler_if.sv | 48 ++++
 rtl/tft_window_scheduler.sv | 154 +++++++++++++++
 tb/tb_tft_window_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_window_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : tft_window_scheduler_if
// Description : Bundle between the TFT timing generator / config master and
//               the window scheduler: pixel request, window config, per-window
//               grants with local coordinates, frame pulse and digit.
// Revision    : 1.0 - initial release
// ============================================================================
interface tft_window_scheduler_if;
  logic        tft_req;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [10:0] cfg_x;
  logic [10:0] cfg_y;
  logic        cfg_pending;
  logic        frame_start;
  logic        tft_req_veneno;
  logic [10:0] hcount_veneno;
  logic [10:0] vcount_veneno;
  logic        tft_req_xiaofang;
  logic [10:0] hcount_xiaofang;
  logic [10:0] vcount_xiaofang;
  logic        tft_req_num;
  logic [10:0] hcount_num;
  logic [10:0] vcount_num;
  logic [3:0]  digit;

  // Timing generator / config side
  modport master (
    output tft_req, hcount, vcount, cfg_we, cfg_sel, cfg_x, cfg_y,
    input  cfg_pending, frame_start,
           tft_req_veneno, hcount_veneno, vcount_veneno,
           tft_req_xiaofang, hcount_xiaofang, vcount_xiaofang,
           tft_req_num, hcount_num, vcount_num, digit
  );

  // Scheduler side
  modport slave (
    input  tft_req, hcount, vcount, cfg_we, cfg_sel, cfg_x, cfg_y,
    output cfg_pending, frame_start,
           tft_req_veneno, hcount_veneno, vcount_veneno,
           tft_req_xiaofang, hcount_xiaofang, vcount_xiaofang,
           tft_req_num, hcount_num, vcount_num, digit
  );
endinterface
`default_nettype wire

// File: rtl/tft_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tft_window_scheduler
// Description : Maps the active-area pixel onto three display windows with
//               fixed priority (num > xiaofang > veneno), emits registered
//               one-hot grants plus window-local coordinates, repositions
//               windows through frame-synchronous shadows and steps a 0-9
//               digit every DIGIT_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tft_window_scheduler #(
  parameter int W0_W         = 48,
  parameter int W0_H         = 16,
  parameter int W1_W         = 32,
  parameter int W1_H         = 32,
  parameter int W2_W         = 8,
  parameter int W2_H         = 16,
  parameter int X0_INIT      = 100,
  parameter int Y0_INIT      = 100,
  parameter int X1_INIT      = 200,
  parameter int Y1_INIT      = 100,
  parameter int X2_INIT      = 300,
  parameter int Y2_INIT      = 100,
  parameter int DIGIT_FRAMES = 30
) (
  input wire                    clk_vga,
  input wire                    rst,
  tft_window_scheduler_if.slave bus
);

  // Index 0 = veneno, 1 = xiaofang, 2 = num (also the priority order, low to high)
  localparam logic [11:0] c_W  [3] = '{12'(W0_W), 12'(W1_W), 12'(W2_W)};
  localparam logic [11:0] c_H  [3] = '{12'(W0_H), 12'(W1_H), 12'(W2_H)};
  localparam logic [10:0] c_XI [3] = '{11'(X0_INIT), 11'(X1_INIT), 11'(X2_INIT)};
  localparam logic [10:0] c_YI [3] = '{11'(Y0_INIT), 11'(Y1_INIT), 11'(Y2_INIT)};
  localparam int          c_CW     = (DIGIT_FRAMES > 1) ? $clog2(DIGIT_FRAMES) : 1;

  logic [10:0]     r_x  [3];
  logic [10:0]     r_y  [3];
  logic [10:0]     r_sx [3];
  logic [10:0]     r_sy [3];
  logic [2:0]      r_pend;
  logic [2:0]      r_gnt;
  logic [10:0]     r_lh [3];
  logic [10:0]     r_lv [3];
  logic            r_fs;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_digit;

  logic            w_fd;
  logic [10:0]     w_x_eff [3];
  logic [10:0]     w_y_eff [3];
  logic [10:0]     w_lh    [3];
  logic [10:0]     w_lv    [3];
  logic [2:0]      w_hit;
  logic [2:0]      w_gnt;

  assign w_fd = bus.tft_req && (bus.hcount == 11'd0) && (bus.vcount == 11'd0);

  // Window hit test and priority grant; pending shadows are already live on the FD pixel
  always_comb begin
    w_gnt = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_x_eff[i] = (w_fd && r_pend[i]) ? r_sx[i] : r_x[i];
      w_y_eff[i] = (w_fd && r_pend[i]) ? r_sy[i] : r_y[i];
      // 12-bit compare so a window extending past 2047 clips instead of wrapping
      w_hit[i]   = bus.tft_req
                && ({1'b0, bus.hcount} >= {1'b0, w_x_eff[i]})
                && ({1'b0, bus.hcount} <  ({1'b0, w_x_eff[i]} + c_W[i]))
                && ({1'b0, bus.vcount} >= {1'b0, w_y_eff[i]})
                && ({1'b0, bus.vcount} <  ({1'b0, w_y_eff[i]} + c_H[i]));
      w_lh[i]    = bus.hcount - w_x_eff[i];
      w_lv[i]    = bus.vcount - w_y_eff[i];
    end
    if (w_hit[2])      w_gnt = 3'b100;
    else if (w_hit[1]) w_gnt = 3'b010;
    else if (w_hit[0]) w_gnt = 3'b001;
  end

  // Register grants, local coordinates (zero when not granted) and the frame pulse
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_gnt <= 3'b000;
      r_fs  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_lh[i] <= 11'd0;
        r_lv[i] <= 11'd0;
      end
    end else begin
      r_gnt <= w_gnt;
      r_fs  <= w_fd;
      for (int i = 0; i < 3; i++) begin
        r_lh[i] <= w_gnt[i] ? w_lh[i] : 11'd0;
        r_lv[i] <= w_gnt[i] ? w_lv[i] : 11'd0;
      end
    end
  end

  // Shadow/active position update; a write in the FD cycle lands after the copy and stays pending
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_pend <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_x[i]  <= c_XI[i];
        r_y[i]  <= c_YI[i];
        r_sx[i] <= c_XI[i];
        r_sy[i] <= c_YI[i];
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_fd && r_pend[i]) begin
          r_x[i]    <= r_sx[i];
          r_y[i]    <= r_sy[i];
          r_pend[i] <= 1'b0;
        end
        if (bus.cfg_we && (bus.cfg_sel == 2'(i))) begin
          r_sx[i]   <= bus.cfg_x;
          r_sy[i]   <= bus.cfg_y;
          r_pend[i] <= 1'b1;
        end
      end
    end
  end

  // Frame-locked digit sequencer, advancing only on frame detect
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_cnt   <= '0;
      r_digit <= 4'd0;
    end else if (w_fd) begin
      if (r_cnt == c_CW'(DIGIT_FRAMES - 1)) begin
        r_cnt   <= '0;
        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

  assign bus.cfg_pending      = |r_pend;
  assign bus.frame_start      = r_fs;
  assign bus.tft_req_veneno   = r_gnt[0];
  assign bus.hcount_veneno    = r_lh[0];
  assign bus.vcount_veneno    = r_lv[0];
  assign bus.tft_req_xiaofang = r_gnt[1];
  assign bus.hcount_xiaofang  = r_lh[1];
  assign bus.vcount_xiaofang  = r_lv[1];
  assign bus.tft_req_num      = r_gnt[2];
  assign bus.hcount_num       = r_lh[2];
  assign bus.vcount_num       = r_lv[2];
  assign bus.digit            = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_tft_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tft_window_scheduler
// Description : Directed, table-driven self-checking bench for
//               tft_window_scheduler (hits, priority, config timing, digit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_window_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  tft_window_scheduler_if bus ();

  tft_window_scheduler dut (
    .clk_vga (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [10:0] h;
    logic [10:0] v;
    logic [2:0]  gnt;   // {num, xiaofang, veneno}
    logic [10:0] lh;
    logic [10:0] lv;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic req, input logic [10:0] h, input logic [10:0] v);
    bus.tft_req = req;
    bus.hcount  = h;
    bus.vcount  = v;
  endtask

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [2:0] gnt,
                         input logic [10:0] lh, input logic [10:0] lv);
    logic [65:0] ec;
    ec = {gnt[0] ? lh : 11'd0, gnt[0] ? lv : 11'd0,
          gnt[1] ? lh : 11'd0, gnt[1] ? lv : 11'd0,
          gnt[2] ? lh : 11'd0, gnt[2] ? lv : 11'd0};
    chk({name, " grant"},
        {63'd0, bus.tft_req_num, bus.tft_req_xiaofang, bus.tft_req_veneno}, {63'd0, gnt});
    chk({name, " coords"},
        {bus.hcount_veneno, bus.vcount_veneno, bus.hcount_xiaofang,
         bus.vcount_xiaofang, bus.hcount_num, bus.vcount_num}, ec);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [10:0] x, input logic [10:0] y);
    bus.cfg_we  = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_x   = x;
    bus.cfg_y   = y;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic do_fd();
    pix(1'b1, 11'd0, 11'd0);
    step();
    pix(1'b0, 11'd0, 11'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fs_bad;
    int fs_pulses;

    // Default windows: veneno 100..147 x 100..115, xiaofang 200..231 x 100..131,
    // num 300..307 x 100..115
    tbl[0]  = '{1'b1, 11'd101, 11'd103, 3'b001, 11'd1,  11'd3};
    tbl[1]  = '{1'b1, 11'd99,  11'd103, 3'b000, 11'd0,  11'd0};
    tbl[2]  = '{1'b1, 11'd147, 11'd115, 3'b001, 11'd47, 11'd15};
    tbl[3]  = '{1'b1, 11'd148, 11'd103, 3'b000, 11'd0,  11'd0};
    tbl[4]  = '{1'b1, 11'd100, 11'd116, 3'b000, 11'd0,  11'd0};
    tbl[5]  = '{1'b1, 11'd200, 11'd100, 3'b010, 11'd0,  11'd0};
    tbl[6]  = '{1'b1, 11'd231, 11'd131, 3'b010, 11'd31, 11'd31};
    tbl[7]  = '{1'b1, 11'd307, 11'd115, 3'b100, 11'd7,  11'd15};
    tbl[8]  = '{1'b1, 11'd308, 11'd100, 3'b000, 11'd0,  11'd0};
    tbl[9]  = '{1'b0, 11'd120, 11'd105, 3'b000, 11'd0,  11'd0};
    tbl[10] = '{1'b1, 11'd100, 11'd99,  3'b000, 11'd0,  11'd0};

    pix(1'b0, 11'd0, 11'd0);
    bus.cfg_we  = 1'b0;
    bus.cfg_sel = 2'd0;
    bus.cfg_x   = 11'd0;
    bus.cfg_y   = 11'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk_win("reset", 3'b000, 11'd0, 11'd0);
    chk("reset digit", {62'd0, bus.digit}, 66'd0);
    chk("reset cfg_pending", {65'd0, bus.cfg_pending}, 66'd0);
    chk("reset frame_start", {65'd0, bus.frame_start}, 66'd0);
    rst = 1'b0;
    step();

    // Table vectors, one clock latency each
    for (int k = 0; k < 11; k++) begin
      pix(tbl[k].req, tbl[k].h, tbl[k].v);
      step();
      chk_win($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].lh, tbl[k].lv);
    end

    // Reset mid-frame drops the grant on the next edge
    pix(1'b1, 11'd101, 11'd103);
    step();
    chk_win("pre-reset hit", 3'b001, 11'd1, 11'd3);
    rst = 1'b1;
    step();
    chk_win("mid-frame reset", 3'b000, 11'd0, 11'd0);
    rst = 1'b0;
    pix(1'b0, 11'd0, 11'd0);
    step();

    // Overlap, last write wins: num -> (600,10) then (100,100)
    cfg_write(2'd2, 11'd600, 11'd10);
    cfg_write(2'd2, 11'd100, 11'd100);
    cfg_write(2'd3, 11'd5, 11'd5);
    chk("num write pending", {65'd0, bus.cfg_pending}, 66'd1);
    do_fd();
    step();
    chk("num applied pending", {65'd0, bus.cfg_pending}, 66'd0);
    pix(1'b1, 11'd104, 11'd105);
    step();
    chk_win("overlap num", 3'b100, 11'd4, 11'd5);
    pix(1'b1, 11'd110, 11'd105);
    step();
    chk_win("overlap veneno", 3'b001, 11'd10, 11'd5);

    // Mid-frame xiaofang move: old position stays until FD
    pix(1'b1, 11'd50, 11'd50);
    cfg_write(2'd1, 11'd400, 11'd50);
    pix(1'b1, 11'd200, 11'd100);
    step();
    chk("xf mid pending", {65'd0, bus.cfg_pending}, 66'd1);
    chk_win("xf old pos", 3'b010, 11'd0, 11'd0);
    do_fd();
    pix(1'b1, 11'd400, 11'd50);
    step();
    chk("xf applied pending", {65'd0, bus.cfg_pending}, 66'd0);
    chk_win("xf new pos", 3'b010, 11'd0, 11'd0);
    pix(1'b1, 11'd200, 11'd100);
    step();
    chk_win("xf old pos gone", 3'b000, 11'd0, 11'd0);

    // Write in the FD cycle itself applies one frame later
    pix(1'b1, 11'd0, 11'd0);
    cfg_write(2'd1, 11'd500, 11'd60);
    chk("fd write pending", {65'd0, bus.cfg_pending}, 66'd1);
    pix(1'b1, 11'd400, 11'd50);
    step();
    chk_win("fd write old pos", 3'b010, 11'd0, 11'd0);
    pix(1'b1, 11'd500, 11'd60);
    step();
    chk_win("fd write not yet", 3'b000, 11'd0, 11'd0);
    do_fd();
    pix(1'b1, 11'd500, 11'd60);
    step();
    chk_win("fd write applied", 3'b010, 11'd0, 11'd0);
    chk("fd write cleared", {65'd0, bus.cfg_pending}, 66'd0);

    // New position is live on the FD pixel itself; frame_start is 1 clk wide
    cfg_write(2'd0, 11'd0, 11'd0);
    pix(1'b1, 11'd0, 11'd0);
    step();
    chk_win("fd pixel new pos", 3'b001, 11'd0, 11'd0);
    chk("frame_start pulse", {65'd0, bus.frame_start}, 66'd1);
    pix(1'b1, 11'd10, 11'd5);
    step();
    chk_win("veneno at origin", 3'b001, 11'd10, 11'd5);
    chk("frame_start low", {65'd0, bus.frame_start}, 66'd0);

    // Window clipped at the right edge never wraps to x=0
    cfg_write(2'd0, 11'd2040, 11'd100);
    do_fd();
    pix(1'b1, 11'd2047, 11'd115);
    step();
    chk_win("edge last col", 3'b001, 11'd7, 11'd15);
    for (int h = 0; h < 8; h++) begin
      pix(1'b1, 11'(h), 11'd105);
      step();
      chk_win($sformatf("edge nowrap h%0d", h), 3'b000, 11'd0, 11'd0);
    end
    pix(1'b0, 11'd2045, 11'd105);
    step();
    chk_win("req low in window", 3'b000, 11'd0, 11'd0);

    // Digit sequencer from a clean reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    pix(1'b0, 11'd0, 11'd0);
    step();
    fs_bad    = 0;
    fs_pulses = 0;
    for (int f = 1; f <= 300; f++) begin
      pix(1'b1, 11'd0, 11'd0);
      step();
      if (bus.frame_start === 1'b1) fs_pulses++;
      pix(1'b1, 11'd5, 11'd0);
      step();
      if (bus.frame_start !== 1'b0) fs_bad++;
      pix(1'b0, 11'd0, 11'd0);
      step();
      if (bus.frame_start !== 1'b0) fs_bad++;
      if (f == 29)  chk("digit after 29", {62'd0, bus.digit}, 66'd0);
      if (f == 30)  chk("digit after 30", {62'd0, bus.digit}, 66'd1);
      if (f == 150) chk("digit after 150", {62'd0, bus.digit}, 66'd5);
      if (f == 270) chk("digit after 270", {62'd0, bus.digit}, 66'd9);
      if (f == 300) chk("digit after 300", {62'd0, bus.digit}, 66'd0);
    end
    chk("frame_start count", 66'(fs_pulses), 66'd300);
    chk("frame_start width", 66'(fs_bad), 66'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
